// File: rtl/unary_reduce_accumulator_pkg.sv
`default_nettype none
//==============================================================================
// Package : unary_reduce_pkg
// Brief   : Opcode/state types and opcode helpers for unary_reduce_accumulator
// Rev     : 1.0 - initial release
//==============================================================================
package unary_reduce_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } reduce_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } reduce_state_e;

    // Codes 6 and 7 have no meaning and collapse onto AND before being stored.
    function automatic reduce_op_e normalize_op(input logic [2:0] code);
        case (code)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: return reduce_op_e'(code);
            default:                            return OP_AND;
        endcase
    endfunction

    function automatic reduce_op_e base_op(input reduce_op_e op);
        case (op)
            OP_OR,  OP_NOR:  return OP_OR;
            OP_XOR, OP_XNOR: return OP_XOR;
            default:         return OP_AND;
        endcase
    endfunction

    function automatic logic is_inverted(input reduce_op_e op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unary_reduce_accumulator_if.sv
`default_nettype none
//==============================================================================
// Interface : unary_reduce_accumulator_if
// Brief     : Input beat stream and result stream; m_beats exists only when
//             UNARY_REDUCE_BEAT_COUNT_EN is defined.
// Rev       : 1.0 - initial release
//==============================================================================
interface unary_reduce_accumulator_if #(
    parameter int N = 8
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
    , parameter int CW = 9
`endif
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         s_last;
    logic [2:0]   s_op;
    logic         m_valid;
    logic         m_ready;
    logic         m_result;
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
    logic [CW-1:0] m_beats;
`endif

    modport master (
        output s_valid, s_data, s_last, s_op, m_ready,
        input  s_ready, m_valid, m_result
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
        , input m_beats
`endif
    );

    modport slave (
        input  s_valid, s_data, s_last, s_op, m_ready,
        output s_ready, m_valid, m_result
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
        , output m_beats
`endif
    );

endinterface
`default_nettype wire

// File: rtl/unary_reduce_accumulator_word_reduce.sv
`default_nettype none
//==============================================================================
// Module : unary_word_reduce
// Brief  : Combinational AND/OR/XOR reduction of one N-bit word.
// Rev    : 1.0 - initial release
//==============================================================================
module unary_word_reduce
    import unary_reduce_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_data,
    input  reduce_op_e   i_op,
    output logic         o_r
);

    always_comb begin
        o_r = &i_data;
        case (i_op)
            OP_OR:   o_r = |i_data;
            OP_XOR:  o_r = ^i_data;
            default: o_r = &i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unary_reduce_accumulator.sv
`default_nettype none
//==============================================================================
// Module : unary_reduce_accumulator
// Brief  : Folds a multi-beat packet into one reduction bit; optional beat
//          count output under UNARY_REDUCE_BEAT_COUNT_EN.
// Rev    : 1.0 - initial release
//==============================================================================
module unary_reduce_accumulator
    import unary_reduce_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_BEATS = 256
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    unary_reduce_accumulator_if.slave  bus
);

    if (N < 1 || MAX_BEATS < 1) begin : g_param_check
        $error("unary_reduce_accumulator: N and MAX_BEATS must be >= 1");
    end

    reduce_state_e r_state;
    reduce_op_e    r_op;
    logic          r_acc;
    logic          r_m_valid;
    logic          r_m_result;

    reduce_op_e    w_op;
    reduce_op_e    w_base;
    logic          w_r;
    logic          w_fire;
    logic          w_acc_next;

    // The opcode is live from the port only on the first beat of a packet.
    assign w_op   = (r_state == IDLE) ? normalize_op(bus.s_op) : r_op;
    assign w_base = base_op(w_op);
    assign w_fire = bus.s_valid && (r_state != HOLD);

    unary_word_reduce #(
        .N (N)
    ) u_word_reduce (
        .i_data (bus.s_data),
        .i_op   (w_base),
        .o_r    (w_r)
    );

    always_comb begin
        w_acc_next = w_r;
        if (r_state == ACCUM) begin
            case (w_base)
                OP_OR:   w_acc_next = r_acc | w_r;
                OP_XOR:  w_acc_next = r_acc ^ w_r;
                default: w_acc_next = r_acc & w_r;
            endcase
        end
    end

    assign bus.s_ready  = (r_state != HOLD);
    assign bus.m_valid  = r_m_valid;
    assign bus.m_result = r_m_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_AND;
            r_acc      <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_result <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_fire) begin
                        r_op  <= w_op;
                        r_acc <= w_acc_next;
                        if (bus.s_last) begin
                            r_state    <= HOLD;
                            r_m_valid  <= 1'b1;
                            r_m_result <= w_acc_next ^ is_inverted(w_op);
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        r_state   <= IDLE;
                        r_m_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef UNARY_REDUCE_BEAT_COUNT_EN
    localparam int              c_cw  = $clog2(MAX_BEATS + 1);
    localparam logic [c_cw-1:0] c_max = c_cw'(MAX_BEATS);

    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] r_beats;
    logic [c_cw-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = c_cw'(1);
        if (r_state != IDLE) begin
            w_cnt_next = (r_cnt == c_max) ? r_cnt : r_cnt + c_cw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_beats <= '0;
        end else if (r_state == HOLD) begin
            if (bus.m_ready) begin
                r_cnt <= '0;
            end
        end else if (w_fire) begin
            r_cnt <= w_cnt_next;
            if (bus.s_last) begin
                r_beats <= w_cnt_next;
            end
        end
    end

    assign bus.m_beats = r_beats;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unary_reduce_accumulator.sv
`default_nettype none
//==============================================================================
// Module : tb_unary_reduce_accumulator
// Brief  : Directed vector table plus hand sequences for unary_reduce_accumulator
//          (beat count checks active with UNARY_REDUCE_BEAT_COUNT_EN).
// Rev    : 1.0 - initial release
//==============================================================================
module tb_unary_reduce_accumulator;

    localparam int c_n = 8;
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
    localparam int c_max_beats = 4;
    localparam int c_cw        = $clog2(c_max_beats + 1);
`else
    localparam int c_max_beats = 256;
`endif
    localparam int c_nvec = 13;

    typedef struct {
        logic [2:0]      op0;
        logic [2:0]      opl;
        int              n;
        logic [7:0][7:0] w;
        logic            exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs [c_nvec];

    unary_reduce_accumulator_if #(
        .N (c_n)
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
        , .CW (c_cw)
`endif
    ) bus ();

    unary_reduce_accumulator #(
        .N         (c_n),
        .MAX_BEATS (c_max_beats)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: actual=0 required=1");
        end
    endtask

    // Drives n beats from a negedge; returns at the negedge after the last accept.
    task automatic send_beats(input logic [2:0] op0, input logic [2:0] opl, input int n,
                              input logic [7:0][7:0] w, input bit do_last);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = w[i];
            bus.s_op    = (i == 0) ? op0 : opl;
            bus.s_last  = do_last && (i == n - 1);
            wait_ready();
            @(negedge clk);
            if (!(do_last && (i == n - 1))) chk("midpkt_mvalid", 32'(bus.m_valid), 32'd0);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] op0, input logic [2:0] opl, input int n,
                                input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                                input logic [7:0] w3, input logic [7:0] w4, input logic [7:0] w5,
                                input logic exp);
        vec_t v;
        v.op0  = op0;
        v.opl  = opl;
        v.n    = n;
        v.w    = '0;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
        v.exp  = exp;
        return v;
    endfunction

    task automatic one_beat(input logic [2:0] op, input logic [7:0] d, input logic exp, input string name);
        logic [7:0][7:0] w;
        w    = '0;
        w[0] = d;
        send_beats(op, op, 1, w, 1'b1);
        chk({name, "_mvalid"}, 32'(bus.m_valid), 32'd1);
        chk({name, "_result"}, 32'(bus.m_result), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        logic [7:0][7:0] w;
        n_checks = 0;
        n_fail   = 0;

        // op0, later-beat op (must be ignored), beats, words, expected result
        vecs[0]  = mk(3'd0, 3'd0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[1]  = mk(3'd2, 3'd2, 3, 8'h01, 8'h03, 8'h07, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[2]  = mk(3'd5, 3'd5, 3, 8'h01, 8'h03, 8'h07, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[3]  = mk(3'd4, 3'd0, 2, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[4]  = mk(3'd1, 3'd1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[5]  = mk(3'd0, 3'd1, 2, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[6]  = mk(3'd3, 3'd3, 2, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[7]  = mk(3'd7, 3'd7, 1, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[8]  = mk(3'd6, 3'd6, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[9]  = mk(3'd1, 3'd0, 3, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[10] = mk(3'd4, 3'd4, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[11] = mk(3'd0, 3'd0, 6, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        vecs[12] = mk(3'd2, 3'd2, 3, 8'h80, 8'hC0, 8'hE0, 8'h00, 8'h00, 8'h00, 1'b0);

        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.s_op    = 3'd0;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_s_ready", 32'(bus.s_ready), 32'd1);
        chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
        chk("reset_m_result", 32'(bus.m_result), 32'd0);
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
        chk("reset_m_beats", 32'(bus.m_beats), 32'd0);
`endif

        for (int i = 0; i < c_nvec; i++) begin
            send_beats(vecs[i].op0, vecs[i].opl, vecs[i].n, vecs[i].w, 1'b1);
            chk($sformatf("v%0d_mvalid", i), 32'(bus.m_valid), 32'd1);
            chk($sformatf("v%0d_result", i), 32'(bus.m_result), 32'(vecs[i].exp));
            chk($sformatf("v%0d_hold_sready", i), 32'(bus.s_ready), 32'd0);
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
            chk($sformatf("v%0d_beats", i), 32'(bus.m_beats),
                32'((vecs[i].n > c_max_beats) ? c_max_beats : vecs[i].n));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_post_sready", i), 32'(bus.s_ready), 32'd1);
            chk($sformatf("v%0d_post_mvalid", i), 32'(bus.m_valid), 32'd0);
        end

        // Backpressure: result held for 5 cycles while the next beat waits.
        bus.m_ready = 1'b0;
        w    = '0;
        w[0] = 8'hFF;
        send_beats(3'd0, 3'd0, 1, w, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h00;
        bus.s_op    = 3'd1;
        bus.s_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_mvalid", 32'(bus.m_valid), 32'd1);
            chk("bp_result", 32'(bus.m_result), 32'd1);
            chk("bp_sready", 32'(bus.s_ready), 32'd0);
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
            chk("bp_beats", 32'(bus.m_beats), 32'd1);
`endif
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_bubble_sready", 32'(bus.s_ready), 32'd1);
        chk("bp_bubble_mvalid", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("bp_next_mvalid", 32'(bus.m_valid), 32'd1);
        chk("bp_next_result", 32'(bus.m_result), 32'd0);
        @(negedge clk);

        // Idle gap mid-packet: XOR of 01,01 with the port opcode changed during the gap.
        w    = '0;
        w[0] = 8'h01;
        send_beats(3'd2, 3'd2, 1, w, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("gap_mvalid", 32'(bus.m_valid), 32'd0);
            chk("gap_sready", 32'(bus.s_ready), 32'd1);
            @(negedge clk);
        end
        send_beats(3'd1, 3'd1, 1, w, 1'b1);
        chk("gap_result", 32'(bus.m_result), 32'd0);
        chk("gap_mvalid_end", 32'(bus.m_valid), 32'd1);
        @(negedge clk);

        // Reset in the middle of a 4-beat AND packet after a result of 1.
        one_beat(3'd1, 8'h80, 1'b1, "pre_rst");
        w    = '0;
        w[0] = 8'hFF;
        w[1] = 8'hFF;
        send_beats(3'd0, 3'd0, 2, w, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mvalid", 32'(bus.m_valid), 32'd0);
        chk("rst_sready", 32'(bus.s_ready), 32'd1);
        chk("rst_result", 32'(bus.m_result), 32'd0);
`ifdef UNARY_REDUCE_BEAT_COUNT_EN
        chk("rst_beats", 32'(bus.m_beats), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_mvalid", 32'(bus.m_valid), 32'd0);
        end
        one_beat(3'd1, 8'h00, 1'b0, "post_rst_or00");
        one_beat(3'd1, 8'h80, 1'b1, "post_rst_or80");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
